// File: rtl/eth_rx_pkg.sv
// Shared definitions for the Ethernet receive path: filter FSM encoding,
// address constants and the saturating counter increment.
package eth_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } rx_state_e;

    localparam logic [47:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam int          ETH_DST_BYTES = 6;

    // Counters of any width up to 64 bits go through this one helper; callers
    // size-cast the result back to their own width.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input logic [63:0] max_value);
        if (value >= max_value) begin
            sat_inc = max_value;
        end else begin
            sat_inc = value + 64'd1;
        end
    endfunction

endpackage

// File: rtl/eth_dst_mac_match.sv
// Destination-address classifier: decides on the first beat whether a frame
// is accepted, given the filter configuration and the runt flag.
module eth_dst_mac_match
    import eth_rx_pkg::*;
(
    input  logic [47:0] dst,
    input  logic        runt,
    input  logic        cfg_enable,
    input  logic        cfg_promisc,
    input  logic        cfg_accept_bcast,
    input  logic        cfg_accept_mcast,
    input  logic [47:0] cfg_local_mac,
    output logic        accept
);

    logic bcast_s;
    logic mcast_s;
    logic ucast_s;

    // Group bit is bit 0 of the first byte on the wire, i.e. dst[0].
    always_comb begin
        bcast_s = (dst == ETH_BCAST_MAC);
        mcast_s = dst[0] & ~bcast_s;
        ucast_s = (dst == cfg_local_mac);
        accept  = cfg_enable & ~runt &
                  (cfg_promisc | ucast_s | (bcast_s & cfg_accept_bcast) | (mcast_s & cfg_accept_mcast));
    end

endmodule

// File: rtl/axis_xgmii_rx_mac_filter_128.sv
// Frame-level destination MAC filter on the 128-bit receive stream with a
// one-cycle registered output and saturating per-class frame counters.
module axis_xgmii_rx_mac_filter_128
    import eth_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int KEEP_WIDTH = 16,
    parameter int USER_WIDTH = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    input  logic                  s_error_bad_fcs,
    input  logic                  cfg_enable,
    input  logic                  cfg_promisc,
    input  logic                  cfg_accept_bcast,
    input  logic                  cfg_accept_mcast,
    input  logic [47:0]           cfg_local_mac,
    input  logic                  stat_clear,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic [CNT_WIDTH-1:0]  stat_frames_ok,
    output logic [CNT_WIDTH-1:0]  stat_frames_bad,
    output logic [CNT_WIDTH-1:0]  stat_frames_dropped
);

    if (DATA_WIDTH != 128 || KEEP_WIDTH != DATA_WIDTH / 8) begin : g_bad_width
        $error("axis_xgmii_rx_mac_filter_128 supports only DATA_WIDTH=128, KEEP_WIDTH=16");
    end
    if (CNT_WIDTH < 1 || CNT_WIDTH > 64 || USER_WIDTH < 1) begin : g_bad_cnt
        $error("axis_xgmii_rx_mac_filter_128: CNT_WIDTH must be 1..64, USER_WIDTH >= 1");
    end

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    rx_state_e             state_r;
    rx_state_e             state_nxt_s;
    logic                  runt_s;
    logic                  accept_s;
    logic                  fwd_s;
    logic                  err_s;
    logic                  frame_end_s;
    logic [USER_WIDTH-1:0] user_s;
    logic [DATA_WIDTH-1:0] tdata_r;
    logic [KEEP_WIDTH-1:0] tkeep_r;
    logic                  tvalid_r;
    logic                  tlast_r;
    logic [USER_WIDTH-1:0] tuser_r;
    logic [CNT_WIDTH-1:0]  ok_r;
    logic [CNT_WIDTH-1:0]  bad_r;
    logic [CNT_WIDTH-1:0]  drop_r;

    eth_dst_mac_match u_match (
        .dst              (s_axis_tdata[ETH_DST_BYTES*8-1:0]),
        .runt             (runt_s),
        .cfg_enable       (cfg_enable),
        .cfg_promisc      (cfg_promisc),
        .cfg_accept_bcast (cfg_accept_bcast),
        .cfg_accept_mcast (cfg_accept_mcast),
        .cfg_local_mac    (cfg_local_mac),
        .accept           (accept_s)
    );

    // Per-beat qualifiers; the error bit only exists on the last beat, so a stray FCS pulse is masked.
    always_comb begin
        runt_s      = s_axis_tlast & ~s_axis_tkeep[ETH_DST_BYTES-1];
        err_s       = s_axis_tlast & (s_axis_tuser[0] | s_error_bad_fcs);
        frame_end_s = s_axis_tvalid & s_axis_tlast;
        user_s      = s_axis_tuser;
        user_s[0]   = err_s;
    end

    // Filter FSM next state and forward decision; only valid beats move it.
    always_comb begin
        state_nxt_s = state_r;
        fwd_s       = 1'b0;
        if (s_axis_tvalid) begin
            case (state_r)
                ST_IDLE: begin
                    fwd_s = accept_s;
                    if (s_axis_tlast) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = accept_s ? ST_PASS : ST_DROP;
                    end
                end
                ST_PASS: begin
                    fwd_s       = 1'b1;
                    state_nxt_s = s_axis_tlast ? ST_IDLE : ST_PASS;
                end
                ST_DROP: begin
                    fwd_s       = 1'b0;
                    state_nxt_s = s_axis_tlast ? ST_IDLE : ST_DROP;
                end
                default: begin
                    fwd_s       = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output stage; suppressed beats leave the bus all-zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdata_r  <= {DATA_WIDTH{1'b0}};
            tkeep_r  <= {KEEP_WIDTH{1'b0}};
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            tuser_r  <= {USER_WIDTH{1'b0}};
        end else begin
            tdata_r  <= fwd_s ? s_axis_tdata : {DATA_WIDTH{1'b0}};
            tkeep_r  <= fwd_s ? s_axis_tkeep : {KEEP_WIDTH{1'b0}};
            tvalid_r <= fwd_s;
            tlast_r  <= fwd_s & s_axis_tlast;
            tuser_r  <= fwd_s ? user_s : {USER_WIDTH{1'b0}};
        end
    end

    // Frame counters: one per frame at its last beat, clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_r   <= {CNT_WIDTH{1'b0}};
            bad_r  <= {CNT_WIDTH{1'b0}};
            drop_r <= {CNT_WIDTH{1'b0}};
        end else if (stat_clear) begin
            ok_r   <= {CNT_WIDTH{1'b0}};
            bad_r  <= {CNT_WIDTH{1'b0}};
            drop_r <= {CNT_WIDTH{1'b0}};
        end else if (frame_end_s) begin
            if (fwd_s && !err_s) begin
                ok_r <= CNT_WIDTH'(sat_inc(64'(ok_r), 64'(CNT_MAX)));
            end else if (fwd_s) begin
                bad_r <= CNT_WIDTH'(sat_inc(64'(bad_r), 64'(CNT_MAX)));
            end else begin
                drop_r <= CNT_WIDTH'(sat_inc(64'(drop_r), 64'(CNT_MAX)));
            end
        end else begin
            ok_r   <= ok_r;
            bad_r  <= bad_r;
            drop_r <= drop_r;
        end
    end

    assign m_axis_tdata        = tdata_r;
    assign m_axis_tkeep        = tkeep_r;
    assign m_axis_tvalid       = tvalid_r;
    assign m_axis_tlast        = tlast_r;
    assign m_axis_tuser        = tuser_r;
    assign stat_frames_ok      = ok_r;
    assign stat_frames_bad     = bad_r;
    assign stat_frames_dropped = drop_r;

endmodule

// File: tb/tb_axis_xgmii_rx_mac_filter_128.sv
// Self-checking bench: frame-level reference model predicts forwarded beats
// (with cycle of arrival) and counter values; a 4-bit-counter copy checks saturation.
module tb_axis_xgmii_rx_mac_filter_128;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] s_axis_tdata;
    logic [15:0]  s_axis_tkeep;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic [0:0]   s_axis_tuser;
    logic         s_error_bad_fcs;
    logic         cfg_enable, cfg_promisc, cfg_accept_bcast, cfg_accept_mcast;
    logic [47:0]  cfg_local_mac;
    logic         stat_clear;
    logic [127:0] m_axis_tdata;
    logic [15:0]  m_axis_tkeep;
    logic         m_axis_tvalid, m_axis_tlast;
    logic [0:0]   m_axis_tuser;
    logic [31:0]  stat_frames_ok, stat_frames_bad, stat_frames_dropped;
    logic [127:0] sm_tdata;
    logic [15:0]  sm_tkeep;
    logic         sm_tvalid, sm_tlast;
    logic [0:0]   sm_tuser;
    logic [3:0]   ss_ok, ss_bad, ss_drop;

    always #5 clk = ~clk;

    axis_xgmii_rx_mac_filter_128 dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_error_bad_fcs(s_error_bad_fcs),
        .cfg_enable(cfg_enable), .cfg_promisc(cfg_promisc), .cfg_accept_bcast(cfg_accept_bcast),
        .cfg_accept_mcast(cfg_accept_mcast), .cfg_local_mac(cfg_local_mac), .stat_clear(stat_clear),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .stat_frames_ok(stat_frames_ok), .stat_frames_bad(stat_frames_bad),
        .stat_frames_dropped(stat_frames_dropped)
    );

    axis_xgmii_rx_mac_filter_128 #(.CNT_WIDTH(4)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_error_bad_fcs(s_error_bad_fcs),
        .cfg_enable(cfg_enable), .cfg_promisc(cfg_promisc), .cfg_accept_bcast(cfg_accept_bcast),
        .cfg_accept_mcast(cfg_accept_mcast), .cfg_local_mac(cfg_local_mac), .stat_clear(stat_clear),
        .m_axis_tdata(sm_tdata), .m_axis_tkeep(sm_tkeep), .m_axis_tvalid(sm_tvalid),
        .m_axis_tlast(sm_tlast), .m_axis_tuser(sm_tuser),
        .stat_frames_ok(ss_ok), .stat_frames_bad(ss_bad), .stat_frames_dropped(ss_drop)
    );

    typedef struct {
        int           cyc;
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
        logic         user;
    } beat_t;

    beat_t exp_q[$];
    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    int    m_ok = 0, m_bad = 0, m_drop = 0;

    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    function automatic logic [15:0] keep_of(input int n);
        return 16'((32'd1 << n) - 32'd1);
    endfunction

    // One clock; checks the output against the beat (if any) due in this cycle.
    task automatic step();
        logic  exp_v;
        beat_t e;
        @(posedge clk);
        #1;
        cyc   = cyc + 1;
        exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        total++;
        if (m_axis_tvalid !== exp_v || sm_tvalid !== exp_v) begin
            bad++;
            $display("FAIL tvalid cyc=%0d got=%b/%b expected=%b", cyc, m_axis_tvalid, sm_tvalid, exp_v);
        end
        if (exp_v) begin
            e = exp_q.pop_front();
            total++;
            if (m_axis_tdata !== e.data || m_axis_tkeep !== e.keep || m_axis_tlast !== e.last
                || m_axis_tuser[0] !== e.user) begin
                bad++;
                $display("FAIL beat cyc=%0d got=%h/%h/%b/%b expected=%h/%h/%b/%b", cyc, m_axis_tdata,
                         m_axis_tkeep, m_axis_tlast, m_axis_tuser[0], e.data, e.keep, e.last, e.user);
            end
        end
    endtask

    task automatic send_frame(input logic [47:0] dst, input int nbeats, input int last_bytes,
                              input logic user_err, input logic fcs_err, input int gapmax,
                              input logic mac_change, input logic clear_on_last);
        logic         acc, runt, bc, err, last;
        int           gaps;
        logic [127:0] d;
        beat_t        e;
        runt = (nbeats == 1) && (last_bytes < 6);
        bc   = (dst == BCAST);
        acc  = cfg_enable && !runt && (cfg_promisc || dst == cfg_local_mac || (bc && cfg_accept_bcast)
               || (dst[0] && !bc && cfg_accept_mcast));
        err  = user_err | fcs_err;
        for (int b = 0; b < nbeats; b++) begin
            gaps = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
            repeat (gaps) begin
                s_axis_tvalid   = 1'b0;
                s_axis_tdata    = {$urandom, $urandom, $urandom, $urandom};
                s_axis_tlast    = 1'($urandom);
                s_error_bad_fcs = 1'($urandom);
                s_axis_tuser    = 1'($urandom);
                step();
            end
            last = (b == nbeats - 1);
            d = {$urandom, $urandom, $urandom, $urandom};
            if (b == 0) d[47:0] = dst;
            s_axis_tvalid   = 1'b1;
            s_axis_tdata    = d;
            s_axis_tkeep    = last ? keep_of(last_bytes) : 16'hFFFF;
            s_axis_tlast    = last;
            s_axis_tuser    = last ? user_err : 1'($urandom);
            s_error_bad_fcs = last ? fcs_err : 1'($urandom);
            stat_clear      = last && clear_on_last;
            if (acc) begin
                e.cyc = cyc + 1; e.data = d; e.keep = s_axis_tkeep; e.last = last;
                e.user = last ? err : 1'b0;
                exp_q.push_back(e);
            end
            step();
            stat_clear = 1'b0;
            if (b == 0 && mac_change) cfg_local_mac = cfg_local_mac ^ 48'h0000_0100_0000;
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_error_bad_fcs = 1'b0; s_axis_tuser = 1'b0;
        if (clear_on_last) begin
            m_ok = 0; m_bad = 0; m_drop = 0;
        end else if (acc && err) begin
            m_bad++;
        end else if (acc) begin
            m_ok++;
        end else begin
            m_drop++;
        end
        total += 2;
        if (stat_frames_ok !== 32'(m_ok) || stat_frames_bad !== 32'(m_bad) || stat_frames_dropped !== 32'(m_drop)) begin
            bad++;
            $display("FAIL stats got=%0d/%0d/%0d expected=%0d/%0d/%0d", stat_frames_ok, stat_frames_bad,
                     stat_frames_dropped, m_ok, m_bad, m_drop);
        end
        if (ss_ok !== 4'(sat15(m_ok)) || ss_bad !== 4'(sat15(m_bad)) || ss_drop !== 4'(sat15(m_drop))) begin
            bad++;
            $display("FAIL sat_stats got=%0d/%0d/%0d expected=%0d/%0d/%0d", ss_ok, ss_bad, ss_drop,
                     sat15(m_ok), sat15(m_bad), sat15(m_drop));
        end
    endtask

    task automatic clear_stats();
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        m_ok = 0; m_bad = 0; m_drop = 0;
        total++;
        if (stat_frames_ok !== 32'd0 || stat_frames_bad !== 32'd0 || stat_frames_dropped !== 32'd0) begin
            bad++;
            $display("FAIL clear got=%0d/%0d/%0d expected=0/0/0", stat_frames_ok, stat_frames_bad, stat_frames_dropped);
        end
    endtask

    task automatic default_cfg();
        cfg_enable = 1'b1; cfg_promisc = 1'b0; cfg_accept_bcast = 1'b0; cfg_accept_mcast = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = 128'd0; s_axis_tkeep = 16'd0; s_axis_tlast = 1'b0;
        s_axis_tuser = 1'b0; s_error_bad_fcs = 1'b0; stat_clear = 1'b0;
        default_cfg();
        cfg_local_mac = 48'h5544_3322_1100;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        total++;
        if (m_axis_tdata !== 128'd0 || m_axis_tkeep !== 16'd0 || m_axis_tlast !== 1'b0 || m_axis_tuser !== 1'b0
            || stat_frames_ok !== 32'd0 || stat_frames_bad !== 32'd0 || stat_frames_dropped !== 32'd0) begin
            bad++;
            $display("FAIL reset_state got=%h/%h/%b/%b/%0d/%0d/%0d expected=all zero", m_axis_tdata, m_axis_tkeep,
                     m_axis_tlast, m_axis_tuser, stat_frames_ok, stat_frames_bad, stat_frames_dropped);
        end
    endtask

    task automatic test_unicast();
        default_cfg();
        send_frame(cfg_local_mac, 4, 16, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        send_frame(48'h9900_0000_0002, 4, 16, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        cfg_promisc = 1'b1;
        send_frame(48'h9900_0000_0002, 4, 16, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        cfg_enable = 1'b0;
        send_frame(cfg_local_mac, 3, 9, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_bcast_mcast();
        default_cfg();
        send_frame(BCAST, 4, 16, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        cfg_accept_bcast = 1'b1;
        send_frame(BCAST, 4, 16, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        send_frame(48'h0100_005E_0001, 2, 12, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        cfg_accept_mcast = 1'b1;
        send_frame(48'h0100_005E_0001, 2, 12, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        cfg_accept_bcast = 1'b0;
        send_frame(BCAST, 2, 12, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_errors();
        default_cfg();
        send_frame(cfg_local_mac, 4, 16, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        send_frame(cfg_local_mac, 3, 5, 1'b1, 1'b0, 2, 1'b0, 1'b0);
        send_frame(48'h9900_0000_0002, 3, 5, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_runt_midcfg();
        default_cfg();
        send_frame(cfg_local_mac, 1, 5, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        send_frame(cfg_local_mac, 1, 6, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        send_frame(cfg_local_mac, 4, 16, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        cfg_local_mac = cfg_local_mac ^ 48'h0000_0100_0000;
        send_frame(48'h9900_0000_0002, 3, 16, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_saturate_clear();
        default_cfg();
        clear_stats();
        for (int i = 0; i < 20; i++) send_frame(cfg_local_mac, 1, 3, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) send_frame(cfg_local_mac, 1, 16, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        send_frame(cfg_local_mac, 2, 16, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [47:0] dst;
        for (int i = 0; i < 150; i++) begin
            cfg_enable       = ($urandom % 8) != 0;
            cfg_promisc      = ($urandom % 4) == 0;
            cfg_accept_bcast = 1'($urandom);
            cfg_accept_mcast = 1'($urandom);
            case ($urandom % 4)
                0: dst = cfg_local_mac;
                1: dst = BCAST;
                2: dst = 48'({$urandom, $urandom}) | 48'd1;
                default: dst = 48'({$urandom, $urandom}) & ~48'd1;
            endcase
            send_frame(dst, int'($urandom_range(5, 1)), int'($urandom_range(16, 1)), 1'($urandom),
                       ($urandom % 3) == 0, 2, 1'b0, 1'b0);
        end
    endtask

    task automatic test_async_reset();
        beat_t e;
        default_cfg();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {$urandom, $urandom, 16'h0, cfg_local_mac};
        s_axis_tkeep  = 16'hFFFF;
        s_axis_tlast  = 1'b0;
        e.cyc = cyc + 1; e.data = s_axis_tdata; e.keep = 16'hFFFF; e.last = 1'b0; e.user = 1'b0;
        exp_q.push_back(e);
        step();
        s_axis_tvalid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 128'd0 || stat_frames_ok !== 32'd0
            || stat_frames_dropped !== 32'd0) begin
            bad++;
            $display("FAIL async_reset got=%b/%h/%0d/%0d expected=0", m_axis_tvalid, m_axis_tdata,
                     stat_frames_ok, stat_frames_dropped);
        end
        exp_q.delete();
        m_ok = 0; m_bad = 0; m_drop = 0;
        step();
        step();
        rst_n = 1'b1;
        step();
        send_frame(48'h9900_0000_0002, 3, 16, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        send_frame(cfg_local_mac, 2, 8, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_bcast_mcast();
        test_errors();
        test_runt_midcfg();
        test_saturate_clear();
        test_random();
        test_async_reset();
        repeat (3) step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_beats got=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
